norm_round_pipe: RTL and testbench

NORM_ROUND_PIPE -- requirements
Module: norm_round_pipe

---
 rtl/norm_round_pipe.sv | 174 +++++++++++++++++
 tb/tb_norm_round_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/norm_round_pipe.sv
// norm_round_pipe
//   Two-stage normalise / round / clamp back end for a floating-point
//   multiplier. S1 normalises the unsigned mantissa product and extracts
//   guard and sticky bits. S2 rounds in the selected mode, then clamps the
//   result to infinity (overflow) or flushes it to zero (underflow).
//   Valid/ready handshake on both sides. Latency is 2 cycles and throughput
//   is 1 beat/cycle.
//
// Optional feature macro: NORM_ROUND_FLAGS_EN
//   defined   : ovf / unf / inexact are computed and registered
//   undefined : the flag outputs are tied to 0 and no flag registers exist
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  input handshake
//   p                    unsigned mantissa product, 2*(MW+1) bits
//   exponent             biased exponent sum, signed, EW bits
//   sign                 result sign
//   rnd_mode             00 nearest-even, 01 toward zero, 10 +inf, 11 -inf
//   out_valid/out_ready  output handshake
//   res_sign/res_exp/res_mant  rounded result (zero while out_valid is low)
//   ovf / unf / inexact  exception flags, qualified by out_valid
module norm_round_pipe #(
  parameter int MW = 23,
  parameter int FE = 8,
  parameter int EW = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*(MW+1)-1:0]   p,
  input  logic signed [EW-1:0]  exponent,
  input  logic                  sign,
  input  logic [1:0]            rnd_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  res_sign,
  output logic [FE-1:0]         res_exp,
  output logic [MW-1:0]         res_mant,
  output logic                  ovf,
  output logic                  unf,
  output logic                  inexact
);

  localparam int PW = 2 * (MW + 1);
  localparam logic signed [EW-1:0] MAXEXP = EW'((1 << FE) - 1);
  localparam logic signed [EW-1:0] ONE    = EW'(1);
  localparam logic signed [EW-1:0] ZERO   = '0;

  function automatic logic round_up(input logic [1:0] mode, input logic g,
                                    input logic s, input logic lsb,
                                    input logic sgn);
    case (mode)
      2'b00:   return g & (s | lsb);
      2'b01:   return 1'b0;
      2'b10:   return (g | s) & ~sgn;
      default: return (g | s) & sgn;
    endcase
  endfunction

  function automatic logic [FE-1:0] clamp_exp(input logic o, input logic u,
                                              input logic [FE-1:0] e);
    if (o)      return '1;
    else if (u) return '0;
    else        return e;
  endfunction

  logic                 vld_p1, vld_p2;
  logic                 adv1, adv2;

  logic [MW-1:0]        mant_p1;
  logic                 guard_p1, sticky_p1, sign_p1;
  logic signed [EW-1:0] exp_p1;
  logic [1:0]           mode_p1;

  logic                 sign_p2;
  logic [FE-1:0]        exp_p2;
  logic [MW-1:0]        mant_p2;

  // A full stage may only move forward when the stage after it moves too.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // ---- S1: normalise ----
  logic                 msb;
  logic [MW-1:0]        mant_n;
  logic                 guard_n, sticky_n;
  logic signed [EW-1:0] exp_n;

  assign msb      = p[PW-1];
  assign mant_n   = msb ? p[2*MW:MW+1] : p[2*MW-1:MW];
  assign guard_n  = msb ? p[MW] : p[MW-1];
  assign sticky_n = msb ? |p[MW-1:0] : |p[MW-2:0];
  assign exp_n    = msb ? exponent + ONE : exponent;

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      mant_p1   <= mant_n;
      guard_p1  <= guard_n;
      sticky_p1 <= sticky_n;
      exp_p1    <= exp_n;
      sign_p1   <= sign;
      mode_p1   <= rnd_mode;
    end
  end

  // ---- S2: round and clamp ----
  logic                 up;
  logic [MW:0]          mant_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic                 ovf_c, unf_c;

  assign up       = round_up(mode_p1, guard_p1, sticky_p1, mant_p1[0], sign_p1);
  // A carry out of the mantissa leaves the low MW bits at zero, which is
  // exactly the renormalised mantissa 1.000..0 one binade higher.
  assign mant_rnd = {1'b0, mant_p1} + {{MW{1'b0}}, up};
  assign exp_rnd  = mant_rnd[MW] ? exp_p1 + ONE : exp_p1;
  assign ovf_c    = exp_rnd >= MAXEXP;
  assign unf_c    = exp_rnd <= ZERO;

  always_ff @(posedge clk) begin
    if (adv2 && vld_p1) begin
      sign_p2 <= sign_p1;
      exp_p2  <= clamp_exp(ovf_c, unf_c, exp_rnd[FE-1:0]);
      mant_p2 <= (ovf_c || unf_c) ? '0 : mant_rnd[MW-1:0];
    end
  end

  // Data registers carry no reset; outputs read as zero whenever no result
  // is being presented, which also covers the reset state.
  assign out_valid = vld_p2;
  assign res_sign  = vld_p2 ? sign_p2 : 1'b0;
  assign res_exp   = vld_p2 ? exp_p2  : '0;
  assign res_mant  = vld_p2 ? mant_p2 : '0;

`ifdef NORM_ROUND_FLAGS_EN
  logic nz_p1;
  logic ovf_p2, unf_p2, inx_p2;

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) nz_p1 <= |p;
  end

  always_ff @(posedge clk) begin
    if (adv2 && vld_p1) begin
      ovf_p2 <= ovf_c;
      unf_p2 <= unf_c;
      // A flushed nonzero value is always inexact even if no bits fell off.
      inx_p2 <= guard_p1 | sticky_p1 | (unf_c & nz_p1);
    end
  end

  assign ovf     = vld_p2 ? ovf_p2 : 1'b0;
  assign unf     = vld_p2 ? unf_p2 : 1'b0;
  assign inexact = vld_p2 ? inx_p2 : 1'b0;
`else
  assign ovf     = 1'b0;
  assign unf     = 1'b0;
  assign inexact = 1'b0;
`endif

endmodule

// File: tb/tb_norm_round_pipe.sv
// Testbench for norm_round_pipe (MW=23, FE=8, EW=10). Directed vectors with
// hand-computed expected results; flag expectations collapse to zero when the
// design is built without NORM_ROUND_FLAGS_EN.
module tb_norm_round_pipe;

`ifdef NORM_ROUND_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [47:0]        p;
  logic signed [9:0]  exponent;
  logic               sign;
  logic [1:0]         rnd_mode;
  logic               out_valid, out_ready;
  logic               res_sign;
  logic [7:0]         res_exp;
  logic [22:0]        res_mant;
  logic               ovf, unf, inexact;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    logic [1:0]  m;
    logic [7:0]  xe;
    logic [22:0] xm;
    logic [2:0]  xf;   // {ovf, unf, inexact}
  } vec_t;

  logic        g_sign, g_ovf, g_unf, g_inx;
  logic [7:0]  g_exp;
  logic [22:0] g_mant;
  int          g_lat;

  norm_round_pipe #(.MW(23), .FE(8), .EW(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .p(p), .exponent(exponent), .sign(sign), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sign(res_sign), .res_exp(res_exp), .res_mant(res_mant),
    .ovf(ovf), .unf(unf), .inexact(inexact)
  );

  always #5 clk = ~clk;

  // Send one beat into an empty pipeline with out_ready high and capture the
  // result plus the number of cycles until it appeared.
  task automatic apply(input vec_t v);
    p = v.p; exponent = v.e; sign = v.s; rnd_mode = v.m;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g_lat = 1;
    while (!out_valid && g_lat < 8) begin
      @(posedge clk); #1;
      g_lat++;
    end
    g_sign = res_sign; g_exp = res_exp; g_mant = res_mant;
    g_ovf = ovf; g_unf = unf; g_inx = inexact;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    p = '0; exponent = '0; sign = 1'b0; rnd_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if ({res_sign, res_exp, res_mant} !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", {res_sign, res_exp, res_mant}); end
    n_tests++; if ({ovf, unf, inexact} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {ovf, unf, inexact}); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_normalise;
    vec_t v[4];
    v[0] = '{48'h800000_000000, 10'd127, 1'b0, 2'b00, 8'd128, 23'h000000, 3'b000};
    v[1] = '{48'hC00000_000000, 10'd100, 1'b0, 2'b00, 8'd101, 23'h400000, 3'b000};
    v[2] = '{48'h600000_000000, 10'd100, 1'b1, 2'b00, 8'd100, 23'h400000, 3'b000};
    v[3] = '{48'h800000_800000, 10'd127, 1'b0, 2'b10, 8'd128, 23'h000001, 3'b001};
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      n_tests++; if (g_lat !== 2) begin n_fail++; $display("FAIL norm_latency[%0d] got %0d want 2", i, g_lat); end
      n_tests++; if ({g_sign, g_exp, g_mant} !== {v[i].s, v[i].xe, v[i].xm}) begin n_fail++; $display("FAIL norm_result[%0d] got %h want %h", i, {g_sign, g_exp, g_mant}, {v[i].s, v[i].xe, v[i].xm}); end
      n_tests++; if ({g_ovf, g_unf, g_inx} !== (v[i].xf & {3{FLG}})) begin n_fail++; $display("FAIL norm_flags[%0d] got %b want %b", i, {g_ovf, g_unf, g_inx}, v[i].xf & {3{FLG}}); end
    end
  endtask

  task automatic test_rounding;
    vec_t v[10];
    v[0] = '{48'h400000_400000, 10'd127, 1'b0, 2'b00, 8'd127, 23'd0, 3'b001};
    v[1] = '{48'h400000_400000, 10'd127, 1'b0, 2'b01, 8'd127, 23'd0, 3'b001};
    v[2] = '{48'h400000_400000, 10'd127, 1'b0, 2'b10, 8'd127, 23'd1, 3'b001};
    v[3] = '{48'h400000_400000, 10'd127, 1'b1, 2'b11, 8'd127, 23'd1, 3'b001};
    v[4] = '{48'h400000_400000, 10'd127, 1'b1, 2'b10, 8'd127, 23'd0, 3'b001};
    v[5] = '{48'h400000_C00000, 10'd127, 1'b0, 2'b00, 8'd127, 23'd2, 3'b001};
    v[6] = '{48'h400000_000001, 10'd127, 1'b0, 2'b00, 8'd127, 23'd0, 3'b001};
    v[7] = '{48'h400000_000001, 10'd127, 1'b1, 2'b11, 8'd127, 23'd1, 3'b001};
    v[8] = '{48'h800000_C00000, 10'd127, 1'b0, 2'b00, 8'd128, 23'd1, 3'b001};
    v[9] = '{48'h400000_000000, 10'd127, 1'b1, 2'b11, 8'd127, 23'd0, 3'b000};
    for (int i = 0; i < 10; i++) begin
      apply(v[i]);
      n_tests++; if ({g_sign, g_exp, g_mant} !== {v[i].s, v[i].xe, v[i].xm}) begin n_fail++; $display("FAIL round_result[%0d] got %h want %h", i, {g_sign, g_exp, g_mant}, {v[i].s, v[i].xe, v[i].xm}); end
      n_tests++; if ({g_ovf, g_unf, g_inx} !== (v[i].xf & {3{FLG}})) begin n_fail++; $display("FAIL round_flags[%0d] got %b want %b", i, {g_ovf, g_unf, g_inx}, v[i].xf & {3{FLG}}); end
    end
  endtask

  task automatic test_overflow;
    vec_t v[4];
    v[0] = '{48'h7FFFFF_C00000, 10'd254, 1'b0, 2'b00, 8'hFF, 23'd0, 3'b101};
    v[1] = '{48'h400000_000000, 10'd254, 1'b0, 2'b00, 8'hFE, 23'd0, 3'b000};
    v[2] = '{48'h400000_000000, 10'd255, 1'b1, 2'b00, 8'hFF, 23'd0, 3'b100};
    v[3] = '{48'h800000_000000, 10'd254, 1'b0, 2'b00, 8'hFF, 23'd0, 3'b100};
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      n_tests++; if ({g_sign, g_exp, g_mant} !== {v[i].s, v[i].xe, v[i].xm}) begin n_fail++; $display("FAIL ovf_result[%0d] got %h want %h", i, {g_sign, g_exp, g_mant}, {v[i].s, v[i].xe, v[i].xm}); end
      n_tests++; if ({g_ovf, g_unf, g_inx} !== (v[i].xf & {3{FLG}})) begin n_fail++; $display("FAIL ovf_flags[%0d] got %b want %b", i, {g_ovf, g_unf, g_inx}, v[i].xf & {3{FLG}}); end
    end
  endtask

  task automatic test_underflow;
    vec_t v[4];
    v[0] = '{48'h400000_000000, 10'h3FF, 1'b0, 2'b00, 8'd0, 23'd0, 3'b011};
    v[1] = '{48'h400000_000000, 10'd0,   1'b1, 2'b00, 8'd0, 23'd0, 3'b011};
    v[2] = '{48'h800000_000000, 10'd0,   1'b0, 2'b00, 8'd1, 23'd0, 3'b000};
    v[3] = '{48'h000000_000000, 10'h3FF, 1'b0, 2'b00, 8'd0, 23'd0, 3'b010};
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      n_tests++; if ({g_sign, g_exp, g_mant} !== {v[i].s, v[i].xe, v[i].xm}) begin n_fail++; $display("FAIL unf_result[%0d] got %h want %h", i, {g_sign, g_exp, g_mant}, {v[i].s, v[i].xe, v[i].xm}); end
      n_tests++; if ({g_ovf, g_unf, g_inx} !== (v[i].xf & {3{FLG}})) begin n_fail++; $display("FAIL unf_flags[%0d] got %b want %b", i, {g_ovf, g_unf, g_inx}, v[i].xf & {3{FLG}}); end
    end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 4);
      in_valid  = (idx < 3);
      p = {2'b01, 23'(idx + 1), 23'b0}; exponent = 10'd127; sign = 1'b0; rnd_mode = 2'b00;
      #1;
      if (c == 2) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready got %b want 0", in_ready); end
      end
      if (c == 2 || c == 3) begin
        n_tests++; if ({out_valid, res_mant} !== {1'b1, 23'd1}) begin n_fail++; $display("FAIL b2b_hold[%0d] got %b/%h want 1/000001", c, out_valid, res_mant); end
      end
      if (out_valid && out_ready) begin
        n_tests++; if (res_mant !== 23'(n + 1)) begin n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", n, res_mant, 23'(n + 1)); end
        n++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    n_tests++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_accepted got %0d want 3", idx); end
    n_tests++; if (n !== 3) begin n_fail++; $display("FAIL b2b_delivered got %0d want 3", n); end
  endtask

  task automatic test_reset_midflight;
    int seen = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      p = {2'b01, 23'(k + 5), 23'b0}; exponent = 10'd127; sign = 1'b0; rnd_mode = 2'b00;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    n_tests++; if ({out_valid, res_mant} !== {1'b1, 23'd5}) begin n_fail++; $display("FAIL mid_inflight got %b/%h want 1/000005", out_valid, res_mant); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    n_tests++; if (res_mant !== 23'd0) begin n_fail++; $display("FAIL mid_rst_mant got %h want 0", res_mant); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mid_stale_results got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_normalise();
    test_rounding();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
